// File: rtl/rs_rx_ctrl.sv
// RS-232 8N1 receive controller: start-edge detect, mid-bit sampling on
// baud ticks, LSB-first assembly and stop-bit framing check.
module rs_rx_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 rs_clk,
    output logic                 rs_ena,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic [SYNC_STAGES-1:0] sync;
    logic                 rxd_s;
    logic                 rxd_d;
    logic [SYNC_STAGES:0] fill;
    logic                 armed;
    logic                 start_edge;
    logic [CW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;

    assign rxd_s = sync[SYNC_STAGES-1];

    // The chain preloads 1 on reset; hold off edge detection until it has
    // been refilled from the line, so a line already low cannot start a frame.
    assign armed      = fill[SYNC_STAGES];
    assign start_edge = armed & rxd_d & ~rxd_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '1;
            rxd_d <= 1'b1;
            fill  <= '0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], rxd};
            rxd_d <= rxd_s;
            fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            rs_ena    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        state  <= START;
                        rs_ena <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                START: begin
                    if (rs_clk) begin
                        if (!rxd_s) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            state  <= IDLE;
                            rs_ena <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (rs_clk) begin
                        shift <= {rxd_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == CW'(DATA_BITS - 1))
                            state <= STOP;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rs_clk) begin
                        state  <= IDLE;
                        rs_ena <= 1'b0;
                        busy   <= 1'b0;
                        if (rxd_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    rs_ena <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_rx_ctrl.sv
// Bench for rs_rx_ctrl: paired with a behavioural baud tick generator,
// frames checked against a byte-level expectation queue.
module tb_rs_rx_ctrl;

    localparam int N1  = 15;
    localparam int N2  = 7;
    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rs_clk;
    logic       rs_ena;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [3:0] bcnt;
    logic       tick_q;
    logic       tick_force = 1'b0;

    int         n_valid = 0;
    int         n_err   = 0;
    int         ena_cyc = 0;
    logic [7:0] got[$];

    logic [7:0] exp_all[$];
    int         exp_err   = 0;
    logic [7:0] last_good = 8'h00;
    int         gi        = 0;

    always #5 clk = ~clk;

    assign rs_clk = tick_q | tick_force;

    rs_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .rs_clk(rs_clk),
        .rs_ena(rs_ena),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    // Baud generator: counts 0..N1 while enabled, ticks when count hits N2.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt   <= '0;
            tick_q <= 1'b0;
        end else if (!rs_ena) begin
            bcnt   <= '0;
            tick_q <= 1'b0;
        end else begin
            bcnt   <= (bcnt == 4'(N1)) ? 4'd0 : bcnt + 4'd1;
            tick_q <= (bcnt == 4'(N2));
        end
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            got.push_back(rx_data);
        end
        if (frame_err) n_err++;
        if (rs_ena) ena_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs,
                           input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int gap);
        rxd = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clk(BIT);
        end
        rxd = stop;
        wait_clk(BIT);
        rxd = 1'b1;
        wait_clk(gap * BIT);
        if (stop) begin
            exp_all.push_back(d);
            last_good = d;
        end else begin
            exp_err++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_nvalid"}, n_valid, exp_all.size());
        chk({tag, "_nerr"}, n_err, exp_err);
        chk({tag, "_data"}, rx_data, last_good);
        chk({tag, "_busy"}, busy, 1'b0);
        while (gi < got.size() && gi < exp_all.size()) begin
            chk({tag, "_byte"}, got[gi], exp_all[gi]);
            gi++;
        end
    endtask

    initial begin
        int e0;
        int v0;
        int r0;
        logic [7:0] d;
        logic       s;
        int         g;

        #2 rst = 1'b0;
        wait_clk(3);
        chk("rst_ena", rs_ena, 1'b0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        wait_clk(8);

        e0 = ena_cyc;
        send_frame(8'h55, 1'b1, 2);
        chk_rng("t1_ena_len", ena_cyc - e0, 148, 158);
        check_model("t1");

        send_frame(8'hA5, 1'b1, 0);
        send_frame(8'h3C, 1'b1, 2);
        check_model("t2");

        send_frame(8'h00, 1'b0, 2);
        check_model("t3");

        e0 = ena_cyc;
        rxd = 1'b0;
        wait_clk(4);
        rxd = 1'b1;
        wait_clk(3 * BIT);
        chk_rng("t4_ena_len", ena_cyc - e0, 7, 11);
        check_model("t4");

        rxd = 1'b0;
        wait_clk(BIT);
        d = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            wait_clk(BIT);
        end
        rxd = d[4];
        wait_clk(8);
        rxd = 1'b0;
        rst = 1'b0;
        #1;
        chk("t5_ena", rs_ena, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_data", rx_data, 8'h00);
        chk("t5_valid", rx_valid, 1'b0);
        chk("t5_ferr", frame_err, 1'b0);
        last_good = 8'h00;
        wait_clk(3);
        rst = 1'b1;
        e0 = ena_cyc;
        wait_clk(40);
        chk("t5_lowline_ena", ena_cyc - e0, 0);
        chk("t5_lowline_busy", busy, 1'b0);
        rxd = 1'b1;
        wait_clk(2 * BIT);
        send_frame(8'h81, 1'b1, 2);
        check_model("t5");

        e0 = ena_cyc;
        v0 = n_valid;
        r0 = n_err;
        for (int i = 0; i < 5; i++) begin
            tick_force = 1'b1;
            wait_clk(1);
            tick_force = 1'b0;
            wait_clk(3 + i);
            chk("t6_busy", busy, 1'b0);
        end
        chk("t6_ena", ena_cyc - e0, 0);
        chk("t6_valid", n_valid - v0, 0);
        chk("t6_ferr", n_err - r0, 0);
        chk("t6_data", rx_data, last_good);

        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            g = s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send_frame(d, s, g);
        end
        wait_clk(2 * BIT);
        check_model("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
